rx_clone_filter: RTL and testbench

RX_CLONE_FILTER -- requirements
Module: rx_clone_filter

---
 rtl/rx_clone_filter_if.sv | 22 ++
 rtl/rx_clone_filter.sv | 253 +++++++++++++++++++++++++
 tb/tb_rx_clone_filter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_clone_filter_if.sv
// Receive-stream and VRAM-write bundle for rx_clone_filter.
// The master drives the received byte stream and observes the VRAM writes;
// the slave (the filter) consumes the stream and issues the writes.
interface rx_clone_filter_if;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_enable;
  logic        data_error;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (
    output data, data_valid, data_enable, data_error,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  data, data_valid, data_enable, data_error,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rx_clone_filter.sv
// Receives cloned frames, checks them with CRC-32, drops redundant
// clones that target the last accepted start address, and copies the
// payload of each accepted frame into VRAM.
module rx_clone_filter #(
  parameter int PAYLOAD_LEN = 1200
) (
  input  logic              clk,
  input  logic              rstb,
  rx_clone_filter_if.slave  bus,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        last_txid,
  output logic [15:0]       cnt_good,
  output logic [15:0]       cnt_err,
  output logic [15:0]       cnt_dup,
  output logic [15:0]       cnt_ovr
);
  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_HDR, S_CLN, S_PAY, S_FCS, S_CHECK, S_COMMIT, S_DROP
  } state_t;

  localparam int          IW          = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam logic [15:0] FRAME_BYTES = 16'(22 + PAYLOAD_LEN);
  localparam logic [15:0] PAY_LAST    = 16'(17 + PAYLOAD_LEN);
  localparam logic [IW-1:0] IDX_LAST  = IW'(PAYLOAD_LEN - 1);
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  // Residue in the MSB-first notation; the register below runs LSB-first.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  state_t        state_q, state_d;
  logic          en_prev_q, en_prev_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic          err_q, err_d;
  logic [7:0]    txid_q, txid_d;
  logic [19:0]   addr_q, addr_d;
  logic [19:0]   last_addr_q, last_addr_d;
  logic          last_addr_vld_q, last_addr_vld_d;
  logic [7:0]    last_txid_q, last_txid_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   cnt_good_q, cnt_good_d, cnt_err_q, cnt_err_d;
  logic [15:0]   cnt_dup_q, cnt_dup_d, cnt_ovr_q, cnt_ovr_d;

  logic [7:0]    pay_mem [PAYLOAD_LEN];
  logic [7:0]    rd_data_q;
  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [IW-1:0] rd_idx;
  logic          acc, rise, pre_active;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = v[31-b];
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign acc  = bus.data_enable & bus.data_valid;
  // en_prev resets high so a frame already in flight at reset release is
  // not seen as a rising edge and is skipped until data_enable drops.
  assign rise = bus.data_enable & ~en_prev_q;

  // Payload buffer: write during PAY, registered read one index ahead of COMMIT.
  always_ff @(posedge clk) begin
    if (mem_we) pay_mem[mem_waddr] <= bus.data;
    rd_data_q <= pay_mem[rd_idx];
  end

  // Next-state, frame parsing, CRC and counter updates.
  always_comb begin
    state_d         = state_q;
    en_prev_d       = bus.data_enable;
    byte_cnt_d      = byte_cnt_q;
    crc_d           = crc_q;
    err_d           = err_q;
    txid_d          = txid_q;
    addr_d          = addr_q;
    last_addr_d     = last_addr_q;
    last_addr_vld_d = last_addr_vld_q;
    last_txid_d     = last_txid_q;
    idx_d           = idx_q;
    frame_done_d    = 1'b0;
    cnt_good_d      = cnt_good_q;
    cnt_err_d       = cnt_err_q;
    cnt_dup_d       = cnt_dup_q;
    cnt_ovr_d       = cnt_ovr_q;
    mem_we          = 1'b0;
    mem_waddr       = IW'(byte_cnt_q - 16'd18);
    rd_idx          = '0;
    // The byte arriving with the enable edge already belongs to the preamble.
    pre_active      = (state_q == S_PRE) || (state_q == S_IDLE && rise);

    if (state_q == S_IDLE && rise) begin
      state_d    = S_PRE;
      err_d      = 1'b0;
      byte_cnt_d = '0;
      crc_d      = CRC_INIT;
    end

    if (acc && (state_q inside {S_HDR, S_CLN, S_PAY, S_FCS})) begin
      crc_d      = crc_next(crc_q, bus.data);
      byte_cnt_d = sat_inc(byte_cnt_q);
      if (bus.data_error) err_d = 1'b1;
    end

    if (pre_active) begin
      if (acc) begin
        if (bus.data_error) err_d = 1'b1;
        if (bus.data == 8'hD5) begin
          state_d    = S_HDR;
          crc_d      = CRC_INIT;
          byte_cnt_d = '0;
        end else if (bus.data != 8'h55) begin
          state_d = S_DROP;
        end
      end else if (!bus.data_enable) begin
        state_d   = S_IDLE;
        cnt_err_d = sat_inc(cnt_err_q);
      end
    end

    case (state_q)
      S_HDR: begin
        if (!bus.data_enable) begin
          state_d   = S_IDLE;
          cnt_err_d = sat_inc(cnt_err_q);
        end else if (acc && byte_cnt_q == 16'd13) begin
          state_d = S_CLN;
        end
      end
      S_CLN: begin
        if (!bus.data_enable) begin
          state_d   = S_IDLE;
          cnt_err_d = sat_inc(cnt_err_q);
        end else if (acc) begin
          if (byte_cnt_q == 16'd14) txid_d = bus.data;
          else                      addr_d = {addr_q[11:0], bus.data};
          if (byte_cnt_q == 16'd17) state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (!bus.data_enable) begin
          state_d   = S_IDLE;
          cnt_err_d = sat_inc(cnt_err_q);
        end else if (acc) begin
          mem_we = 1'b1;
          if (byte_cnt_q == PAY_LAST) state_d = S_FCS;
        end
      end
      S_FCS: begin
        if (!bus.data_enable) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (err_q || bitrev32(crc_q) != CRC_RESIDUE || byte_cnt_q != FRAME_BYTES ||
            txid_q == 8'd0 || txid_q > 8'd7) begin
          cnt_err_d = sat_inc(cnt_err_q);
        end else if (last_addr_vld_q && addr_q == last_addr_q) begin
          cnt_dup_d = sat_inc(cnt_dup_q);
        end else begin
          last_addr_d     = addr_q;
          last_addr_vld_d = 1'b1;
          last_txid_d     = txid_q;
          cnt_good_d      = sat_inc(cnt_good_q);
          idx_d           = '0;
          state_d         = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // A new frame cannot be taken while committing; it is counted and,
        // because its edge is consumed here, ignored until it ends.
        if (rise) cnt_ovr_d = sat_inc(cnt_ovr_q);
        if (idx_q == IDX_LAST) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else begin
          idx_d  = idx_q + 1'b1;
          rd_idx = idx_q + 1'b1;
        end
      end
      S_DROP: begin
        if (!bus.data_enable) begin
          state_d   = S_IDLE;
          cnt_err_d = sat_inc(cnt_err_q);
        end
      end
      default: ;
    endcase
  end

  // State and bookkeeping registers with asynchronous reset.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q         <= S_IDLE;
      en_prev_q       <= 1'b1;
      byte_cnt_q      <= '0;
      crc_q           <= CRC_INIT;
      err_q           <= 1'b0;
      txid_q          <= '0;
      addr_q          <= '0;
      last_addr_q     <= '0;
      last_addr_vld_q <= 1'b0;
      last_txid_q     <= '0;
      idx_q           <= '0;
      frame_done_q    <= 1'b0;
      cnt_good_q      <= '0;
      cnt_err_q       <= '0;
      cnt_dup_q       <= '0;
      cnt_ovr_q       <= '0;
    end else begin
      state_q         <= state_d;
      en_prev_q       <= en_prev_d;
      byte_cnt_q      <= byte_cnt_d;
      crc_q           <= crc_d;
      err_q           <= err_d;
      txid_q          <= txid_d;
      addr_q          <= addr_d;
      last_addr_q     <= last_addr_d;
      last_addr_vld_q <= last_addr_vld_d;
      last_txid_q     <= last_txid_d;
      idx_q           <= idx_d;
      frame_done_q    <= frame_done_d;
      cnt_good_q      <= cnt_good_d;
      cnt_err_q       <= cnt_err_d;
      cnt_dup_q       <= cnt_dup_d;
      cnt_ovr_q       <= cnt_ovr_d;
    end
  end

  assign busy        = (state_q == S_COMMIT);
  assign bus.wr_en   = busy;
  assign bus.wr_addr = busy ? last_addr_q + 20'(idx_q) : '0;
  assign bus.wr_data = busy ? rd_data_q : '0;
  assign frame_done  = frame_done_q;
  assign last_txid   = last_txid_q;
  assign cnt_good    = cnt_good_q;
  assign cnt_err     = cnt_err_q;
  assign cnt_dup     = cnt_dup_q;
  assign cnt_ovr     = cnt_ovr_q;
endmodule

// File: tb/tb_rx_clone_filter.sv
// Directed bench for rx_clone_filter with a 16-byte payload.
module tb_rx_clone_filter;
  localparam int PL = 16;
  localparam int M_GOOD = 0, M_FLIP = 1, M_BADPRE = 2, M_TRUNC = 3, M_DERR = 4, M_GAPS = 5;

  logic        clk = 1'b0;
  logic        rstb;
  logic        busy, frame_done;
  logic [7:0]  last_txid;
  logic [15:0] cnt_good, cnt_err, cnt_dup, cnt_ovr;

  rx_clone_filter_if bus();

  rx_clone_filter #(.PAYLOAD_LEN(PL)) dut (
    .clk(clk), .rstb(rstb), .bus(bus), .busy(busy), .frame_done(frame_done),
    .last_txid(last_txid), .cnt_good(cnt_good), .cnt_err(cnt_err),
    .cnt_dup(cnt_dup), .cnt_ovr(cnt_ovr)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic [7:0]  txid;
    logic [19:0] addr;
    logic [7:0]  seed;
    int          mode;
    bit          exp_wr;
    int          exp_good, exp_err, exp_dup;
    logic [7:0]  exp_txid;
  } vec_t;

  vec_t        vecs [13];
  int          n_checks = 0, n_errors = 0;
  logic [27:0] wlog [$];
  int          fd_cnt = 0, busy_bad = 0;
  logic [7:0]  frame_q [$];
  logic [7:0]  pay_ref [PL];
  logic [7:0]  ref_save [PL];

  // Observe the write port and pulses half a cycle away from the clock edge.
  always @(negedge clk) begin
    if (bus.wr_en) wlog.push_back({bus.wr_addr, bus.wr_data});
    if (frame_done) fd_cnt++;
    if (busy !== bus.wr_en) busy_bad++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic build_frame(input logic [7:0] txid, input logic [19:0] addr,
                             input logic [7:0] seed, input int mode);
    logic [31:0] crc;
    frame_q.delete();
    repeat (7) frame_q.push_back(8'h55);
    frame_q.push_back(8'hD5);
    for (int i = 0; i < 14; i++) frame_q.push_back(8'(8'hA0 + i));
    frame_q.push_back(txid);
    frame_q.push_back({4'hA, addr[19:16]});  // upper nibble must be ignored
    frame_q.push_back(addr[15:8]);
    frame_q.push_back(addr[7:0]);
    for (int i = 0; i < PL; i++) begin
      pay_ref[i] = 8'(seed + 8'(i * 37));
      frame_q.push_back(pay_ref[i]);
    end
    crc = 32'hFFFFFFFF;
    for (int i = 8; i < frame_q.size(); i++) crc = crc_upd(crc, frame_q[i]);
    crc = ~crc;
    frame_q.push_back(crc[7:0]);
    frame_q.push_back(crc[15:8]);
    frame_q.push_back(crc[23:16]);
    frame_q.push_back(crc[31:24]);
    if (mode == M_FLIP)   frame_q[29] = frame_q[29] ^ 8'h10;
    if (mode == M_BADPRE) frame_q[3] = 8'h12;
    if (mode == M_TRUNC)  while (frame_q.size() > 34) void'(frame_q.pop_back());
  endtask

  task automatic send_frame(input int mode);
    for (int i = 0; i < frame_q.size(); i++) begin
      bus.data_enable = 1'b1;
      if (mode == M_GAPS && (i % 5) == 4) begin
        bus.data_valid = 1'b0;
        bus.data       = 8'hD5;
        @(posedge clk); #1;
      end
      bus.data_valid = 1'b1;
      bus.data       = frame_q[i];
      bus.data_error = (mode == M_DERR && i == 12);
      @(posedge clk); #1;
    end
    bus.data_enable = 1'b0;
    bus.data_valid  = 1'b0;
    bus.data_error  = 1'b0;
    bus.data        = 8'h00;
  endtask

  task automatic check_writes(input string tag, input logic [19:0] base);
    check($sformatf("%s wr_count", tag), 32'(wlog.size()), 32'(PL));
    if (wlog.size() == PL)
      for (int i = 0; i < PL; i++)
        check($sformatf("%s write%0d", tag, i), 32'(wlog[i]), 32'({20'(base + 20'(i)), ref_save[i]}));
  endtask

  initial begin
    int  nw;
    bit  got;
    vecs[0]  = '{8'd1, 20'h00100, 8'h10, M_GOOD,   1'b1, 1, 0, 0, 8'd1};
    vecs[1]  = '{8'd2, 20'h00100, 8'h10, M_GOOD,   1'b0, 1, 0, 1, 8'd1};
    vecs[2]  = '{8'd3, 20'h00100, 8'h10, M_GOOD,   1'b0, 1, 0, 2, 8'd1};
    vecs[3]  = '{8'd4, 20'h00110, 8'h20, M_FLIP,   1'b0, 1, 1, 2, 8'd1};
    vecs[4]  = '{8'd4, 20'h00110, 8'h20, M_GOOD,   1'b1, 2, 1, 2, 8'd4};
    vecs[5]  = '{8'd5, 20'hFFFF8, 8'h30, M_GOOD,   1'b1, 3, 1, 2, 8'd5};
    vecs[6]  = '{8'd0, 20'h00200, 8'h40, M_GOOD,   1'b0, 3, 2, 2, 8'd5};
    vecs[7]  = '{8'd8, 20'h00200, 8'h40, M_GOOD,   1'b0, 3, 3, 2, 8'd5};
    vecs[8]  = '{8'd6, 20'h00200, 8'h40, M_BADPRE, 1'b0, 3, 4, 2, 8'd5};
    vecs[9]  = '{8'd6, 20'h00200, 8'h40, M_TRUNC,  1'b0, 3, 5, 2, 8'd5};
    vecs[10] = '{8'd6, 20'h00200, 8'h40, M_DERR,   1'b0, 3, 6, 2, 8'd5};
    vecs[11] = '{8'd7, 20'h00200, 8'h50, M_GAPS,   1'b1, 4, 6, 2, 8'd7};
    vecs[12] = '{8'd1, 20'h00200, 8'h50, M_GOOD,   1'b0, 4, 6, 3, 8'd7};

    rstb = 1'b1;
    bus.data = 8'h00; bus.data_valid = 1'b0; bus.data_enable = 1'b0; bus.data_error = 1'b0;
    idle(3);
    check("reset wr_en", 32'(bus.wr_en), 32'd0);
    check("reset wr_addr", 32'(bus.wr_addr), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset counters", 32'(cnt_good | cnt_err | cnt_dup | cnt_ovr), 32'd0);
    check("reset last_txid", 32'(last_txid), 32'd0);
    rstb = 1'b0;
    idle(3);

    for (int v = 0; v < 13; v++) begin
      wlog.delete(); fd_cnt = 0;
      build_frame(vecs[v].txid, vecs[v].addr, vecs[v].seed, vecs[v].mode);
      ref_save = pay_ref;
      send_frame(vecs[v].mode);
      idle(30);
      if (vecs[v].exp_wr) check_writes($sformatf("v%0d", v), vecs[v].addr);
      else check($sformatf("v%0d wr_count", v), 32'(wlog.size()), 32'd0);
      check($sformatf("v%0d cnt_good", v), 32'(cnt_good), 32'(vecs[v].exp_good));
      check($sformatf("v%0d cnt_err", v), 32'(cnt_err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d cnt_dup", v), 32'(cnt_dup), 32'(vecs[v].exp_dup));
      check($sformatf("v%0d last_txid", v), 32'(last_txid), 32'(vecs[v].exp_txid));
      check($sformatf("v%0d frame_done", v), 32'(fd_cnt), vecs[v].exp_wr ? 32'd1 : 32'd0);
    end

    // Second frame starts four cycles into a commit.
    wlog.delete(); fd_cnt = 0;
    build_frame(8'd1, 20'h00300, 8'h11, M_GOOD);
    ref_save = pay_ref;
    send_frame(M_GOOD);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = bus.wr_en; end
    check("A commit_start", 32'(got), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    build_frame(8'd2, 20'h00400, 8'h22, M_GOOD);
    send_frame(M_GOOD);
    idle(30);
    check_writes("A", 20'h00300);
    check("A cnt_ovr", 32'(cnt_ovr), 32'd1);
    check("A cnt_good", 32'(cnt_good), 32'd5);
    check("A frame_done", 32'(fd_cnt), 32'd1);

    // Second frame rises on the last commit cycle.
    wlog.delete(); fd_cnt = 0;
    build_frame(8'd3, 20'h00600, 8'h33, M_GOOD);
    ref_save = pay_ref;
    send_frame(M_GOOD);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = bus.wr_en && bus.wr_addr == 20'h0060F;
    end
    check("B last_write_seen", 32'(got), 32'd1);
    build_frame(8'd4, 20'h00700, 8'h44, M_GOOD);
    send_frame(M_GOOD);
    idle(30);
    check_writes("B", 20'h00600);
    check("B cnt_ovr", 32'(cnt_ovr), 32'd2);
    check("B cnt_good", 32'(cnt_good), 32'd6);
    check("B frame_done", 32'(fd_cnt), 32'd1);

    // Reset at the fifth write of a commit, then the same address again.
    build_frame(8'd5, 20'h00500, 8'h55, M_GOOD);
    ref_save = pay_ref;
    send_frame(M_GOOD);
    nw = 0;
    for (int k = 0; k < 40 && nw < 5; k++) begin
      @(negedge clk);
      if (bus.wr_en) nw++;
    end
    check("C fifth_write_seen", 32'(nw), 32'd5);
    rstb = 1'b1;
    #1;
    check("C async wr_en", 32'(bus.wr_en), 32'd0);
    check("C async busy", 32'(busy), 32'd0);
    check("C async counters", 32'(cnt_good | cnt_err | cnt_dup | cnt_ovr), 32'd0);
    check("C async last_txid", 32'(last_txid), 32'd0);
    @(negedge clk);
    rstb = 1'b0;
    idle(3);
    wlog.delete(); fd_cnt = 0;
    send_frame(M_GOOD);
    idle(30);
    check_writes("C", 20'h00500);
    check("C cnt_good", 32'(cnt_good), 32'd1);
    check("C cnt_dup", 32'(cnt_dup), 32'd0);
    check("C last_txid", 32'(last_txid), 32'd5);

    // Reset in the middle of a frame: the rest of it is ignored.
    wlog.delete(); fd_cnt = 0;
    build_frame(8'd2, 20'h00800, 8'h66, M_GOOD);
    ref_save = pay_ref;
    fork
      send_frame(M_GOOD);
      begin
        repeat (20) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
      end
    join
    idle(30);
    check("D wr_count", 32'(wlog.size()), 32'd0);
    check("D cnt_good", 32'(cnt_good), 32'd0);
    check("D cnt_err", 32'(cnt_err), 32'd0);
    check("D frame_done", 32'(fd_cnt), 32'd0);
    wlog.delete(); fd_cnt = 0;
    send_frame(M_GOOD);
    idle(30);
    check_writes("D retry", 20'h00800);
    check("D retry cnt_good", 32'(cnt_good), 32'd1);

    check("busy tracks wr_en", 32'(busy_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
